// File: rtl/fetch_pkg.sv
// Shared definitions for the parametrised instruction-fetch datapath:
// FSM state encoding, SRAM strobe levels and default widths.
package fetch_pkg;

  // Fetch sequencer states. The pause states only exist in hardware when
  // the single-step feature is compiled in.
  typedef enum logic [2:0] {
    HALTED = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    FETCH3 = 3'd3,
    PAUSE1 = 3'd4,
    PAUSE2 = 3'd5
  } fetch_state_t;

  // SRAM strobes are active-low.
  localparam logic SRAM_ACTIVE = 1'b0;
  localparam logic SRAM_IDLE   = 1'b1;

  // Default geometry, matching the original 16-bit datapath.
  localparam int DEFAULT_ADDR_W   = 16;
  localparam int DEFAULT_DATA_W   = 16;
  localparam int DEFAULT_MEM_WAIT = 1;

  // Wait-state counter width; covers MEM_WAIT values 0..15.
  localparam int WAIT_CNT_W = 4;

  // Strobe level for a given state: only FETCH2 talks to the SRAM.
  function automatic logic sram_strobe(input fetch_state_t st);
    return (st == FETCH2) ? SRAM_ACTIVE : SRAM_IDLE;
  endfunction

endpackage

// File: rtl/reg_n.sv
// Generic N-bit register with synchronous active-low reset and load
// enable. Used for the PC, IR, MAR and MDR of the fetch datapath.
module reg_n
  import fetch_pkg::*;
#(
  parameter int N = DEFAULT_DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Hold the value unless loaded; reset clears to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit_p.sv
// Parametrised instruction-fetch unit: PC -> MAR -> SRAM -> MDR -> IR,
// with a configurable number of SRAM wait states and a registered-source
// bus mux feeding the hex display.
//
// Build option: define FETCH_PAUSE_EN to stop after every fetch and wait
// for a Continue press/release (single-stepping). Without it the unit
// free-runs once started and only reset returns it to HALTED.
module fetch_unit_p
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int MEM_WAIT = DEFAULT_MEM_WAIT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Run,
  input  logic              Continue,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic              UB,
  output logic              LB,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] bus_value,
  output logic              pause
);

  // Last value of the wait counter in FETCH2 (MEM_WAIT extra cycles).
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_WAIT);

  fetch_state_t            state;
  fetch_state_t            state_next;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic                    wait_done;

  logic [ADDR_W-1:0]       pc_next;
  logic [ADDR_W-1:0]       mar;
  logic [DATA_W-1:0]       mdr;
  logic                    pc_en;
  logic                    mar_en;
  logic                    mdr_en;
  logic                    ir_en;
  logic                    sram_sel;

  assign wait_done = (wait_cnt == WAIT_LAST);

  // State register; reset forces HALTED from any state, which also
  // deasserts the SRAM strobes on that same edge.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= HALTED;
    end else begin
      state <= state_next;
    end
  end

  // Sequencer: HALTED waits for Run, then FETCH1/FETCH2/FETCH3 repeat,
  // optionally pausing after each instruction.
  always_comb begin
    state_next = state;
    case (state)
      HALTED:  if (Run) state_next = FETCH1;
      FETCH1:  state_next = FETCH2;
      FETCH2:  if (wait_done) state_next = FETCH3;
`ifdef FETCH_PAUSE_EN
      FETCH3:  state_next = PAUSE1;
      PAUSE1:  if (Continue) state_next = PAUSE2;
      PAUSE2:  if (!Continue) state_next = FETCH1;
`else
      FETCH3:  state_next = FETCH1;
`endif
      default: state_next = HALTED;
    endcase
  end

  // Wait counter runs 0..MEM_WAIT while in FETCH2 and is zero elsewhere,
  // so every FETCH2 visit lasts exactly MEM_WAIT+1 cycles.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wait_cnt <= '0;
    end else if ((state == FETCH2) && !wait_done) begin
      wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Register load controls. The external PC load is only honoured while
  // halted; in the same cycle as Run it still lands before FETCH1 reads PC.
  always_comb begin
    pc_en   = 1'b0;
    pc_next = pc_load_val;
    if (state == FETCH1) begin
      pc_en   = 1'b1;
      pc_next = pc + ADDR_W'(1);
    end else if ((state == HALTED) && pc_load) begin
      pc_en   = 1'b1;
      pc_next = pc_load_val;
    end
    mar_en = (state == FETCH1);
    mdr_en = (state == FETCH2) && wait_done;
    ir_en  = (state == FETCH3);
  end

  reg_n #(.N(ADDR_W)) u_pc (
    .clk   (Clk),
    .rst_n (Reset),
    .load  (pc_en),
    .d     (pc_next),
    .q     (pc)
  );

  reg_n #(.N(ADDR_W)) u_mar (
    .clk   (Clk),
    .rst_n (Reset),
    .load  (mar_en),
    .d     (pc),
    .q     (mar)
  );

  reg_n #(.N(DATA_W)) u_mdr (
    .clk   (Clk),
    .rst_n (Reset),
    .load  (mdr_en),
    .d     (mem_rdata),
    .q     (mdr)
  );

  reg_n #(.N(DATA_W)) u_ir (
    .clk   (Clk),
    .rst_n (Reset),
    .load  (ir_en),
    .d     (mdr),
    .q     (ir)
  );

  // Bus mux replacing the old tri-state bus: every source is a register,
  // so the displayed value never floats. PC is zero-extended to DATA_W.
  always_comb begin
    bus_value = ir;
    case (state)
      FETCH1:  bus_value = DATA_W'(pc);
      FETCH3:  bus_value = mdr;
      default: bus_value = ir;
    endcase
  end

  // SRAM pins: strobes decode directly from the registered state so they
  // cannot glitch; this block never writes, so WE stays idle.
  assign sram_sel = sram_strobe(state);
  assign CE       = sram_sel;
  assign OE       = sram_sel;
  assign UB       = sram_sel;
  assign LB       = sram_sel;
  assign WE       = SRAM_IDLE;
  assign mem_addr = mar;

`ifdef FETCH_PAUSE_EN
  assign pause = (state == PAUSE1) || (state == PAUSE2);
`else
  logic unused_continue;
  assign unused_continue = Continue;
  assign pause           = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit_p.sv
// Self-checking bench for fetch_unit_p. Expected behaviour comes from an
// arithmetic timeline model: after leaving HALTED at address S, fetch k
// occupies cycles k*P .. k*P+P-1 (P = MEM_WAIT+3) and reads mem[S+k].
// Works with or without FETCH_PAUSE_EN defined.
module tb_fetch_unit_p;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int MEM_WAIT = 1;
  localparam int P        = MEM_WAIT + 3;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
`ifdef FETCH_PAUSE_EN
  localparam bit PAUSE_MODE = 1'b1;
`else
  localparam bit PAUSE_MODE = 1'b0;
`endif

  logic              Clk;
  logic              Reset;
  logic              Run;
  logic              Continue;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              CE, OE, WE, UB, LB;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] bus_value;
  logic              pause;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int n_compared   = 0;
  int n_mismatched = 0;

  fetch_unit_p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WAIT(MEM_WAIT)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Run         (Run),
    .Continue    (Continue),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .CE          (CE),
    .OE          (OE),
    .WE          (WE),
    .UB          (UB),
    .LB          (LB),
    .ir          (ir),
    .pc          (pc),
    .bus_value   (bus_value),
    .pause       (pause)
  );

  // Asynchronous SRAM: data follows the address combinationally.
  assign mem_rdata = mem[mem_addr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
  endtask

  task automatic do_reset();
    Reset = 1'b0; Run = 1'b0; Continue = 1'b0; pc_load = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
  endtask

  // Start from HALTED (just reset, IR=0) at address start and check every
  // cycle against the timeline model for ncyc cycles.
  task automatic run_check(input logic [ADDR_W-1:0] start, input int ncyc,
                           input bit noise, input string tag);
    logic [ADDR_W-1:0] exp_pc, exp_addr;
    logic [DATA_W-1:0] exp_ir, exp_bus;
    logic              exp_sel, exp_pause;
    int                phase, kdone;
    pc_load = 1'b1; pc_load_val = start; Run = 1'b1;
    tick();
    pc_load = 1'b0; Run = 1'b0;
    for (int t = 1; t <= ncyc; t++) begin
      if (noise) begin
        pc_load     = 1'($urandom_range(0, 1));
        pc_load_val = ADDR_W'($urandom);
        Run         = 1'($urandom_range(0, 1));
      end
      tick();
      phase = t % P;
      kdone = t / P;
      if (PAUSE_MODE && t >= P) begin
        exp_ir    = mem[start];
        exp_pc    = start + ADDR_W'(1);
        exp_addr  = start;
        exp_sel   = 1'b1;
        exp_pause = 1'b1;
        exp_bus   = exp_ir;
      end else begin
        exp_ir    = (kdone == 0) ? '0 : mem[ADDR_W'(start + kdone - 1)];
        exp_pc    = ADDR_W'(start + (t + P - 1) / P);
        exp_addr  = ADDR_W'(start + kdone);
        exp_sel   = !((phase >= 1) && (phase <= MEM_WAIT + 1));
        exp_pause = 1'b0;
        if (phase == 0)          exp_bus = DATA_W'(exp_pc);
        else if (phase == P - 1) exp_bus = mem[exp_addr];
        else                     exp_bus = exp_ir;
      end
      n_compared++;
      if (ir !== exp_ir) begin
        n_mismatched++;
        $display("[TB] FAIL %s ir t=%0d: got %h want %h", tag, t, ir, exp_ir);
      end
      n_compared++;
      if (pc !== exp_pc) begin
        n_mismatched++;
        $display("[TB] FAIL %s pc t=%0d: got %h want %h", tag, t, pc, exp_pc);
      end
      n_compared++;
      if ({CE, OE, UB, LB, WE} !== {{4{exp_sel}}, 1'b1}) begin
        n_mismatched++;
        $display("[TB] FAIL %s strobes t=%0d: got %b want %b", tag, t,
                 {CE, OE, UB, LB, WE}, {{4{exp_sel}}, 1'b1});
      end
      n_compared++;
      if (pause !== exp_pause) begin
        n_mismatched++;
        $display("[TB] FAIL %s pause t=%0d: got %b want %b", tag, t, pause, exp_pause);
      end
      n_compared++;
      if (bus_value !== exp_bus) begin
        n_mismatched++;
        $display("[TB] FAIL %s bus t=%0d: got %h want %h", tag, t, bus_value, exp_bus);
      end
      if (!exp_sel) begin
        n_compared++;
        if (mem_addr !== exp_addr) begin
          n_mismatched++;
          $display("[TB] FAIL %s mem_addr t=%0d: got %h want %h", tag, t, mem_addr, exp_addr);
        end
      end
    end
    pc_load = 1'b0; Run = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; Run = 1'b0; Continue = 1'b0; pc_load = 1'b0; pc_load_val = '0;
    tick();
    tick();
    n_compared++;
    if ({pc, ir, mem_addr, bus_value} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset regs: got pc=%h ir=%h addr=%h bus=%h want all 0",
               pc, ir, mem_addr, bus_value);
    end
    n_compared++;
    if ({CE, OE, WE, UB, LB, pause} !== 6'b111110) begin
      n_mismatched++;
      $display("[TB] FAIL reset strobes: got %b want 111110", {CE, OE, WE, UB, LB, pause});
    end
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_compared++;
    if ({CE, pc} !== {1'b1, ADDR_W'(0)}) begin
      n_mismatched++;
      $display("[TB] FAIL reset idle: got CE=%b pc=%h want CE=1 pc=0", CE, pc);
    end
  endtask

  task automatic test_first_fetch();
    mem[0] = DATA_W'(32'h1234);
    mem[1] = DATA_W'(32'hABCD);
    do_reset();
    run_check('0, P + 4, 1'b0, "first_fetch");
  endtask

`ifdef FETCH_PAUSE_EN
  // Continue held for 10 cycles then released must give exactly one fetch.
  task automatic test_continue();
    int waited;
    Continue = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_compared++;
      if ({pause, CE, ir} !== {2'b11, mem[0]}) begin
        n_mismatched++;
        $display("[TB] FAIL continue_hold: got pause=%b CE=%b ir=%h want 1 1 %h",
                 pause, CE, ir, mem[0]);
      end
    end
    Continue = 1'b0;
    waited = 0;
    while ((ir === mem[0]) && (waited < 50)) begin
      tick();
      waited++;
    end
    n_compared++;
    if (waited != P + 1) begin
      n_mismatched++;
      $display("[TB] FAIL continue_latency: got %0d cycles want %0d", waited, P + 1);
    end
    n_compared++;
    if ({ir, pc, pause} !== {mem[1], ADDR_W'(2), 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL continue_fetch: got ir=%h pc=%h pause=%b want %h 0002 1",
               ir, pc, pause, mem[1]);
    end
    for (int i = 0; i < 8; i++) tick();
    n_compared++;
    if ({ir, pc, CE} !== {mem[1], ADDR_W'(2), 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL continue_single: got ir=%h pc=%h CE=%b want %h 0002 1",
               ir, pc, CE, mem[1]);
    end
  endtask
`endif

  task automatic test_wrap();
    do_reset();
    run_check(ADDR_MAX, 3 * P + 2, 1'b0, "wrap");
  endtask

  task automatic test_pc_load_ignored();
    logic [ADDR_W-1:0] start;
    start = ADDR_W'($urandom);
    do_reset();
    pc_load = 1'b1; pc_load_val = start; Run = 1'b1;
    tick();
    pc_load = 1'b0; Run = 1'b0;
    tick();
    pc_load = 1'b1; pc_load_val = ~start;
    tick();
    pc_load = 1'b0;
    n_compared++;
    if ({pc, mem_addr, CE} !== {start + ADDR_W'(1), start, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL pc_load_ignored: got pc=%h addr=%h CE=%b want %h %h 0",
               pc, mem_addr, CE, start + ADDR_W'(1), start);
    end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      run_check(ADDR_W'($urandom), $urandom_range(2 * P, 5 * P), 1'b1, "random_run");
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    pc_load = 1'b1; pc_load_val = ADDR_W'($urandom); Run = 1'b1;
    tick();
    pc_load = 1'b0; Run = 1'b0;
    tick();
    n_compared++;
    if (CE !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL mid_fetch_entry: got CE=%b want 0", CE);
    end
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_compared++;
      if ({CE, OE, pc, ir, mem_addr} !== {2'b11, ADDR_W'(0), DATA_W'(0), ADDR_W'(0)}) begin
        n_mismatched++;
        $display("[TB] FAIL mid_fetch_reset: got CE=%b OE=%b pc=%h ir=%h addr=%h want 1 1 0 0 0",
                 CE, OE, pc, ir, mem_addr);
      end
    end
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_compared++;
    if ({CE, pc, ir} !== {1'b1, ADDR_W'(0), DATA_W'(0)}) begin
      n_mismatched++;
      $display("[TB] FAIL mid_fetch_halted: got CE=%b pc=%h ir=%h want 1 0 0", CE, pc, ir);
    end
  endtask

  initial begin
    Reset = 1'b0; Run = 1'b0; Continue = 1'b0; pc_load = 1'b0; pc_load_val = '0;
    fill_mem();
    $display("[TB] start: MEM_WAIT=%0d pause_mode=%0d", MEM_WAIT, PAUSE_MODE);
    test_reset();
    test_first_fetch();
`ifdef FETCH_PAUSE_EN
    test_continue();
`endif
    test_wrap();
    test_pc_load_ignored();
    test_random_runs();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
